// File: rtl/heap_ctrl_pkg.sv
// Shared definitions for the heap request controller: op encoding, FSM states,
// and default widths.
package heap_ctrl_pkg;

  localparam int DEFAULT_NUM_CLIENTS = 4;
  localparam int DEFAULT_DATA_W      = 8;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requester at or above ptr wins, otherwise the
// lowest requester overall (wrap-around).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic         found;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IDX_W'(gi) >= ptr);
  end

  assign masked    = req & hi_mask;
  assign grant_any = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the lowest requester.
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/heap_arbiter.sv
// Shares one priority heap among several clients: round-robin grant, one heap
// op in flight, and a one-cycle response strobe back to the granted client.
module heap_arbiter
  import heap_ctrl_pkg::*;
#(
  parameter int NUM_CLIENTS = DEFAULT_NUM_CLIENTS,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  input  logic [NUM_CLIENTS-1:0]        req_op,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             heap_data_in,
  output logic                          heap_insert,
  output logic                          heap_delete,
  input  logic [DATA_W-1:0]             heap_data_out,
  input  logic                          heap_full,
  input  logic                          heap_empty,
  output logic                          busy
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  state_t            state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              op_reg;
  logic [DATA_W-1:0] data_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [NUM_CLIENTS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   sel_op;
  logic [DATA_W-1:0]      sel_data;
  logic [IDX_W-1:0]       ptr_next;
  logic                   reject;
  logic                   in_idle;
  logic                   in_resp;
  logic                   issue_ok;

  rr_arbiter #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_op   = OP_INSERT;
    sel_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant[i]) begin
        sel_op   = req_op[i];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Heap flags settle one cycle after a strobe, long before the next ISSUE.
  assign reject = (op_reg == OP_INSERT) ? heap_full : heap_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      idx_reg    <= '0;
      op_reg     <= OP_INSERT;
      data_reg   <= '0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            idx_reg    <= grant_idx;
            op_reg     <= sel_op;
            data_reg   <= sel_data;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            rr_ptr_reg <= ptr_next;
            state_reg  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (reject) begin
            err_reg   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (op_reg == OP_DELETE) begin
            rdata_reg <= heap_data_out;
          end
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Every output is gated by reset so an aborted op never leaks a strobe.
  assign in_idle  = (state_reg == ST_IDLE)  && !reset;
  assign in_resp  = (state_reg == ST_RESP)  && !reset;
  assign issue_ok = (state_reg == ST_ISSUE) && !reset && !reject;

  assign req_ready    = in_idle ? grant : '0;
  assign heap_insert  = issue_ok && (op_reg == OP_INSERT);
  assign heap_delete  = issue_ok && (op_reg == OP_DELETE);
  assign heap_data_in = heap_insert ? data_reg : '0;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_rsp
    assign rsp_valid[gi] = in_resp && (idx_reg == IDX_W'(gi));
  end

  assign rsp_data = in_resp ? rdata_reg : '0;
  assign rsp_err  = in_resp && err_reg;
  assign busy     = (state_reg != ST_IDLE) && !reset;

endmodule
